// File: rtl/current_averager.sv
// ---------------------------------------------------------------------------
// current_averager
//   Moving average of unsigned motor-current ADC samples over a window of
//   2^LOG2_WINDOW samples. A running sum is kept next to a circular sample
//   buffer: each accepted sample adds itself and subtracts the entry it
//   overwrites. The mean is the sum shifted right by LOG2_WINDOW, so entries
//   not yet written count as zero.
//
//   After reset, and after every clear, the block spends 2^LOG2_WINDOW cycles
//   in FLUSH zeroing one buffer entry per cycle. busy is high during that
//   time, and incoming samples are dropped.
//
// Parameters
//   SAMPLE_WIDTH : ADC sample width (8..16)
//   LOG2_WINDOW  : log2 of the window depth (1..8)
//
// Ports
//   clock           : rising-edge clock
//   reset           : synchronous, active-high reset
//   sample_valid    : one-cycle strobe qualifying sample_data
//   sample_data     : unsigned raw sample
//   clear           : one-cycle flush request (takes priority over a sample)
//   current_average : windowed mean, zero-extended to 32 bits
//   average_valid   : the window holds 2^LOG2_WINDOW real samples
//   busy            : flushing, samples dropped
//
// Optional feature (macro CURRENT_AVERAGER_OVERCURRENT_EN)
//   overcurrent_threshold : input, 32-bit limit
//   overcurrent           : output, sticky flag. It is set one cycle after a
//                           valid average exceeds the limit, and it is
//                           cleared only by clear or reset.
// ---------------------------------------------------------------------------
module current_averager #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int LOG2_WINDOW  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    clear,
`ifdef CURRENT_AVERAGER_OVERCURRENT_EN
    input  logic [31:0]             overcurrent_threshold,
    output logic                    overcurrent,
`endif
    output logic [31:0]             current_average,
    output logic                    average_valid,
    output logic                    busy
);

    localparam int DEPTH = 1 << LOG2_WINDOW;
    localparam int SUM_W = SAMPLE_WIDTH + LOG2_WINDOW;
    localparam logic [LOG2_WINDOW:0] FILL_MAX = (LOG2_WINDOW + 1)'(DEPTH);

    typedef enum logic {FLUSH, RUN} state_t;

    state_t                  state, state_next;
    logic [LOG2_WINDOW-1:0]  flush_idx;
    logic [LOG2_WINDOW-1:0]  wr_ptr;
    logic [LOG2_WINDOW:0]    fill;
    logic [SUM_W-1:0]        sum;
    logic [SAMPLE_WIDTH-1:0] sample_buf [DEPTH];
    logic                    accept;
    logic                    sum_updated;   // sum changed last edge; publish it now

    // clear wins over a coincident sample
    assign accept = (state == RUN) && sample_valid && !clear;
    assign busy   = (state == FLUSH);

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) state <= FLUSH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = FLUSH;
        end else begin
            case (state)
                FLUSH:   if (&flush_idx) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = FLUSH;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            flush_idx   <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            sum_updated <= 1'b0;
        end else if (state == FLUSH) begin
            flush_idx   <= flush_idx + 1'b1;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            sum_updated <= 1'b0;
        end else begin
            sum_updated <= accept;
            if (accept) begin
                // The oldest entry is already part of sum, so the result stays
                // within SUM_W bits.
                sum    <= sum + SUM_W'(sample_data) - SUM_W'(sample_buf[wr_ptr]);
                wr_ptr <= wr_ptr + 1'b1;   // natural wrap at DEPTH
                if (fill != FILL_MAX) fill <= fill + 1'b1;
            end
        end
    end

    // The buffer has no reset. The flush zeroes every entry before RUN can
    // read one, so contents from before a reset are never used.
    always_ff @(posedge clock) begin
        if (!reset && !clear) begin
            if (state == FLUSH)  sample_buf[flush_idx] <= '0;
            else if (accept)     sample_buf[wr_ptr]    <= sample_data;
        end
    end

    // Outputs move only one cycle after an accepted sample, and hold otherwise.
    always_ff @(posedge clock) begin
        if (reset || clear || state == FLUSH) begin
            current_average <= '0;
            average_valid   <= 1'b0;
        end else if (sum_updated) begin
            current_average <= 32'(sum >> LOG2_WINDOW);
            average_valid   <= (fill == FILL_MAX);
        end
    end

`ifdef CURRENT_AVERAGER_OVERCURRENT_EN
    always_ff @(posedge clock) begin
        if (reset || clear)
            overcurrent <= 1'b0;
        else if (average_valid && (current_average > overcurrent_threshold))
            overcurrent <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_current_averager.sv
// ---------------------------------------------------------------------------
// tb_current_averager
//   Drives directed and random stimulus into current_averager and compares
//   the outputs every cycle against a reference model. The model keeps the
//   accepted samples in a queue and computes the mean by plain arithmetic.
//   Directed checks against constant values cover the key scenarios.
// ---------------------------------------------------------------------------
module tb_current_averager;

    localparam int SW = 12;
    localparam int LW = 4;
    localparam int D  = 1 << LW;

    logic          clock = 1'b0;
    logic          reset;
    logic          sample_valid;
    logic [SW-1:0] sample_data;
    logic          clear;
    logic [31:0]   current_average;
    logic          average_valid;
    logic          busy;
    logic [31:0]   thr;
`ifdef CURRENT_AVERAGER_OVERCURRENT_EN
    logic          overcurrent;
`endif

    current_averager #(.SAMPLE_WIDTH(SW), .LOG2_WINDOW(LW)) dut (
        .clock           (clock),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .clear           (clear),
`ifdef CURRENT_AVERAGER_OVERCURRENT_EN
        .overcurrent_threshold(thr),
        .overcurrent     (overcurrent),
`endif
        .current_average (current_average),
        .average_valid   (average_valid),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned win[$];     // accepted samples, newest last, at most D entries
    int          m_flush;    // flush cycles remaining
    int unsigned out_avg, pend_avg;
    bit          out_vld, pend_vld, m_oc;

    function automatic int unsigned win_mean();
        int unsigned s = 0;
        foreach (win[i]) s += win[i];
        return s / D;        // missing entries count as zero
    endfunction

    // Apply one cycle of inputs, advance the model by one edge, then check.
    task automatic step(input bit r, input bit c, input bit v, input int unsigned d);
        bit acc;
        reset        = r;
        clear        = c;
        sample_valid = v;
        sample_data  = SW'(d);
        @(posedge clock);
        if (r || c) begin
            m_flush  = D;
            win.delete();
            out_avg  = 0; pend_avg = 0;
            out_vld  = 0; pend_vld = 0;
            m_oc     = 0;
        end else begin
            if (out_vld && out_avg > thr) m_oc = 1;
            acc = (m_flush == 0) && v;
            if (m_flush > 0) m_flush--;
            out_avg = pend_avg;
            out_vld = pend_vld;
            if (acc) begin
                win.push_back(d);
                if (win.size() > D) void'(win.pop_front());
                pend_avg = win_mean();
                pend_vld = (win.size() == D);
            end
        end
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_flush > 0});
        chk("avg", current_average, out_avg);
        chk("avg_valid", {31'd0, average_valid}, {31'd0, out_vld});
`ifdef CURRENT_AVERAGER_OVERCURRENT_EN
        chk("overcurrent", {31'd0, overcurrent}, {31'd0, m_oc});
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; clear = 0; sample_valid = 0; sample_data = '0; thr = 32'd1000;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_avg", current_average, 32'd0);

        // After reset is released, busy falls on the 16th edge.
        for (int i = 1; i <= D; i++) begin
            step(0, 0, 0, 0);
            if (i == D - 1) chk("busy_15", {31'd0, busy}, 32'd1);
        end
        chk("busy_16", {31'd0, busy}, 32'd0);
        chk("idle_avg", current_average, 32'd0);
        chk("idle_vld", {31'd0, average_valid}, 32'd0);

        // Sixteen back-to-back samples of 100.
        for (int i = 0; i < D; i++) begin
            step(0, 0, 1, 100);
            if (i == 8) begin   // the output now reflects 8 samples
                chk("half_avg", current_average, 32'd50);
                chk("half_vld", {31'd0, average_valid}, 32'd0);
            end
        end
        idle(1);
        chk("full_avg", current_average, 32'd100);
        chk("full_vld", {31'd0, average_valid}, 32'd1);
        idle(3);
        chk("hold_avg", current_average, 32'd100);

        // The window wraps: sixteen samples of 4095 replace the 100s.
        for (int i = 0; i < D; i++) begin
            step(0, 0, 1, 4095);
            if (i == 8) chk("wrap_mid", current_average, 32'd2097);
        end
        idle(1);
        chk("wrap_avg", current_average, 32'd4095);
        chk("wrap_vld", {31'd0, average_valid}, 32'd1);

        // A clear that coincides with a sample drops the sample and flushes.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 300);
        step(0, 1, 1, 4000);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < D; i++) step(0, 0, 0, 0);
        chk("clr_busy15", {31'd0, busy}, 32'd1);
        idle(1);
        chk("clr_busy16", {31'd0, busy}, 32'd0);
        chk("clr_avg", current_average, 32'd0);
        chk("clr_vld", {31'd0, average_valid}, 32'd0);

        // A reset mid-window must leave no trace of the 200s.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 200);
        step(1, 0, 0, 0);
        idle(D);
        for (int i = 0; i < D; i++) begin
            step(0, 0, 1, 10);
            if (i == 8) chk("rst_mid", current_average, 32'd5);
        end
        idle(1);
        chk("rst_avg10", current_average, 32'd10);
        chk("rst_vld10", {31'd0, average_valid}, 32'd1);

`ifdef CURRENT_AVERAGER_OVERCURRENT_EN
        thr = 32'd1000;
        for (int i = 0; i < D; i++) step(0, 0, 1, 1200);
        idle(2);
        chk("oc_set", {31'd0, overcurrent}, 32'd1);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0);
        idle(2);
        chk("oc_low_avg", current_average, 32'd0);
        chk("oc_sticky", {31'd0, overcurrent}, 32'd1);
        step(0, 1, 0, 0);
        chk("oc_clear", {31'd0, overcurrent}, 32'd0);
        idle(D);
`endif

        // Random traffic: mostly samples, with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            int unsigned p;
            p = $urandom_range(0, 999);
            if (i % 500 == 0) thr = $urandom_range(0, 4095);
            step(p < 8, (p >= 8) && (p < 25), $urandom_range(0, 9) < 7,
                 $urandom_range(0, (1 << SW) - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
